// File: rtl/traffic_conflict_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_conflict_monitor_if
// Description : Lamp inputs, software clear and fault/override outputs of the
//               traffic conflict safety monitor, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_conflict_monitor_if;
  logic       Ra, Ya, Ga;
  logic       Rb, Yb, Gb;
  logic       clear_fault;
  logic       fault;
  logic [2:0] fault_code;
  logic       force_override;
  logic       flash_red;
  logic [7:0] fault_count;

  // Side that drives the lamps and clear request and observes the monitor
  modport master (
    output Ra, Ya, Ga, Rb, Yb, Gb, clear_fault,
    input  fault, fault_code, force_override, flash_red, fault_count
  );

  // The monitor itself
  modport slave (
    input  Ra, Ya, Ga, Rb, Yb, Gb, clear_fault,
    output fault, fault_code, force_override, flash_red, fault_count
  );
endinterface
`default_nettype wire

// File: rtl/traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_conflict_monitor
// Description : Independent safety monitor for the two-head lamp outputs.
//               Detects conflicting greens, multiple lamps, dark heads, short
//               yellows and illegal colour sequences, latches the first fault
//               and drives an all-red flash override until cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_DARK   = 2,
  parameter int FLASH_HALF = 4
) (
  input  wire logic               clk,
  input  wire logic               reset,
  traffic_conflict_monitor_if.slave bus
);

  localparam int DW = $clog2(MAX_DARK + 2);
  localparam int YW = $clog2(MIN_YELLOW + 2);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam logic [DW-1:0] DARK_MAX   = DW'(MAX_DARK);
  localparam logic [YW-1:0] YEL_MIN    = YW'(MIN_YELLOW);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  // Colour encoding of the last single colour shown by a head
  localparam logic [1:0] COL_R = 2'd0;
  localparam logic [1:0] COL_Y = 2'd1;
  localparam logic [1:0] COL_G = 2'd2;

  typedef enum logic [1:0] {
    S_MONITOR  = 2'd0,
    S_FAULT    = 2'd1,
    S_CLEARING = 2'd2
  } state_t;

  // Head index 0 = street A, 1 = street B; lamp bits are {R, Y, G}
  logic [1:0][2:0]    lamp_q, lamp_d;
  logic [1:0][DW-1:0] dark_cnt_q, dark_cnt_d;
  logic [1:0][YW-1:0] yel_cnt_q, yel_cnt_d;
  logic [1:0][1:0]    last_q, last_d;
  state_t             state_q, state_d;
  logic               fault_q, fault_d;
  logic [2:0]         code_q, code_d;
  logic               override_q, override_d;
  logic               flash_q, flash_d;
  logic [FW-1:0]      flash_cnt_q, flash_cnt_d;
  logic [7:0]         count_q, count_d;
  logic               ok_q, ok_d;

  logic [1:0]      head_active, head_single, head_dark, head_multi;
  logic [1:0][1:0] head_colour;
  logic [1:0]      v_dark, v_short, v_seq;
  logic [2:0]      viol_code;

  // Only R->G, G->Y and Y->R are legal colour changes
  function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
    return ((from == COL_R) && (to == COL_G)) ||
           ((from == COL_G) && (to == COL_Y)) ||
           ((from == COL_Y) && (to == COL_R));
  endfunction

  // Decode the registered lamps and rank violations, lowest code first
  always_comb begin
    lamp_d[0] = {bus.Ra, bus.Ya, bus.Ga};
    lamp_d[1] = {bus.Rb, bus.Yb, bus.Gb};
    for (int h = 0; h < 2; h++) begin
      head_active[h] = lamp_q[h][1] | lamp_q[h][0];
      head_multi[h]  = (lamp_q[h][2] & lamp_q[h][1]) | (lamp_q[h][2] & lamp_q[h][0]) |
                       (lamp_q[h][1] & lamp_q[h][0]);
      head_dark[h]   = ~|lamp_q[h];
      head_single[h] = ~head_multi[h] & ~head_dark[h];
      head_colour[h] = lamp_q[h][2] ? COL_R : (lamp_q[h][1] ? COL_Y : COL_G);
      v_dark[h]      = head_dark[h] && (dark_cnt_q[h] >= DARK_MAX);
      v_short[h]     = head_single[h] && (head_colour[h] == COL_R) &&
                       (last_q[h] == COL_Y) && (yel_cnt_q[h] < YEL_MIN);
      v_seq[h]       = head_single[h] && (head_colour[h] != last_q[h]) &&
                       !legal_step(last_q[h], head_colour[h]);
    end
    if (head_active[0] && head_active[1]) viol_code = 3'd1;
    else if (|head_multi)                 viol_code = 3'd2;
    else if (|v_dark)                     viol_code = 3'd3;
    else if (|v_short)                    viol_code = 3'd4;
    else if (|v_seq)                      viol_code = 3'd5;
    else                                  viol_code = 3'd0;
  end

  // Next-state: per-head history, fault latch, flash timer and clear handshake
  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    code_d      = code_q;
    override_d  = override_q;
    flash_d     = flash_q;
    flash_cnt_d = flash_cnt_q;
    count_d     = count_q;
    ok_d        = ok_q;

    // History always tracks the lamps; it is wiped when monitoring resumes
    for (int h = 0; h < 2; h++) begin
      if (head_dark[h])
        dark_cnt_d[h] = (dark_cnt_q[h] >= DARK_MAX) ? dark_cnt_q[h] : dark_cnt_q[h] + 1'b1;
      else
        dark_cnt_d[h] = '0;
      if (head_single[h] && (head_colour[h] == COL_Y))
        yel_cnt_d[h] = (yel_cnt_q[h] >= YEL_MIN) ? yel_cnt_q[h] : yel_cnt_q[h] + 1'b1;
      else if (head_single[h])
        yel_cnt_d[h] = '0;
      else
        yel_cnt_d[h] = yel_cnt_q[h];
      last_d[h] = head_single[h] ? head_colour[h] : last_q[h];
    end

    // Flash timer runs in both fault-holding states
    if (state_q != S_MONITOR) begin
      if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_d = '0;
        flash_d     = ~flash_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_MONITOR: begin
        if (viol_code != 3'd0) begin
          state_d     = S_FAULT;
          fault_d     = 1'b1;
          code_d      = viol_code;
          override_d  = 1'b1;
          flash_d     = 1'b1;
          flash_cnt_d = '0;
          count_d     = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        end
      end
      S_FAULT: begin
        if (bus.clear_fault) begin
          state_d = S_CLEARING;
          ok_d    = 1'b0;
        end
      end
      S_CLEARING: begin
        // Require two consecutive cycles of both heads at single red
        if ((lamp_q[0] == 3'b100) && (lamp_q[1] == 3'b100)) begin
          if (ok_q) begin
            state_d     = S_MONITOR;
            fault_d     = 1'b0;
            code_d      = 3'd0;
            override_d  = 1'b0;
            flash_d     = 1'b0;
            flash_cnt_d = '0;
            ok_d        = 1'b0;
            dark_cnt_d  = '0;
            yel_cnt_d   = '0;
            last_d      = {COL_R, COL_R};
          end else begin
            ok_d = 1'b1;
          end
        end else begin
          ok_d = 1'b0;
        end
      end
      default: state_d = S_MONITOR;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      lamp_q      <= '0;
      dark_cnt_q  <= '0;
      yel_cnt_q   <= '0;
      last_q      <= {COL_R, COL_R};
      state_q     <= S_MONITOR;
      fault_q     <= 1'b0;
      code_q      <= 3'd0;
      override_q  <= 1'b0;
      flash_q     <= 1'b0;
      flash_cnt_q <= '0;
      count_q     <= 8'd0;
      ok_q        <= 1'b0;
    end else begin
      lamp_q      <= lamp_d;
      dark_cnt_q  <= dark_cnt_d;
      yel_cnt_q   <= yel_cnt_d;
      last_q      <= last_d;
      state_q     <= state_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      override_q  <= override_d;
      flash_q     <= flash_d;
      flash_cnt_q <= flash_cnt_d;
      count_q     <= count_d;
      ok_q        <= ok_d;
    end
  end

  assign bus.fault          = fault_q;
  assign bus.fault_code     = code_q;
  assign bus.force_override = override_q;
  assign bus.flash_red      = flash_q;
  assign bus.fault_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_conflict_monitor
// Description : Directed self-checking bench for traffic_conflict_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_conflict_monitor;

  localparam logic [2:0] LR  = 3'b100;
  localparam logic [2:0] LY  = 3'b010;
  localparam logic [2:0] LG  = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  traffic_conflict_monitor_if bus ();

  traffic_conflict_monitor #(
    .MIN_YELLOW (3),
    .MAX_DARK   (2),
    .FLASH_HALF (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lamps(input logic [2:0] a, input logic [2:0] b);
    {bus.Ra, bus.Ya, bus.Ga} = a;
    {bus.Rb, bus.Yb, bus.Gb} = b;
  endtask

  // Stimulus only: clear pulse followed by two cycles of red on both heads
  task automatic do_clear();
    set_lamps(LR, LR);
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    tick();
    tick();
  endtask

  // Stimulus only: one-cycle green/green conflict, then red; fault is visible on return
  task automatic inject_conflict();
    set_lamps(LG, LG);
    tick();
    set_lamps(LR, LR);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.clear_fault = 1'b0;
    set_lamps(LR, LR);
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
    n_cmp++; if (bus.fault_code !== 3'd0) begin n_err++; $display("FAIL reset_code: got %0d want 0", bus.fault_code); end
    n_cmp++; if (bus.force_override !== 1'b0) begin n_err++; $display("FAIL reset_override: got %b want 0", bus.force_override); end
    n_cmp++; if (bus.flash_red !== 1'b0) begin n_err++; $display("FAIL reset_flash: got %b want 0", bus.flash_red); end
    n_cmp++; if (bus.fault_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.fault_count); end
  endtask

  // A: G3 Y3 then red while B does G3 Y3; 17 full periods end on B yellow
  task automatic test_normal_cycle();
    int bad;
    bad = 0;
    for (int i = 0; i < 204; i++) begin
      case ((i % 12) / 3)
        0: set_lamps(LG, LR);
        1: set_lamps(LY, LR);
        2: set_lamps(LR, LG);
        default: set_lamps(LR, LY);
      endcase
      tick();
      if (bus.fault !== 1'b0) bad++;
    end
    set_lamps(LR, LR);
    tick();
    tick();
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL normal_cycles_faulted: got %0d want 0", bad); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL normal_fault: got %b want 0", bus.fault); end
    n_cmp++; if (bus.fault_code !== 3'd0) begin n_err++; $display("FAIL normal_code: got %0d want 0", bus.fault_code); end
    n_cmp++; if (bus.fault_count !== 8'd0) begin n_err++; $display("FAIL normal_count: got %0d want 0", bus.fault_count); end
  endtask

  task automatic test_conflict();
    logic exp_flash;
    set_lamps(LG, LG);
    tick();
    set_lamps(LR, LR);
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL conflict_latency: got %b want 0", bus.fault); end
    tick();
    n_cmp++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL conflict_fault: got %b want 1", bus.fault); end
    n_cmp++; if (bus.fault_code !== 3'd1) begin n_err++; $display("FAIL conflict_code: got %0d want 1", bus.fault_code); end
    n_cmp++; if (bus.force_override !== 1'b1) begin n_err++; $display("FAIL conflict_override: got %b want 1", bus.force_override); end
    n_cmp++; if (bus.fault_count !== 8'd1) begin n_err++; $display("FAIL conflict_count: got %0d want 1", bus.fault_count); end
    for (int i = 0; i < 12; i++) begin
      exp_flash = ((i / 4) % 2) == 0;
      n_cmp++; if (bus.flash_red !== exp_flash) begin n_err++; $display("FAIL flash_cycle_%0d: got %b want %b", i, bus.flash_red, exp_flash); end
      tick();
    end
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    n_cmp++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL clear_enter: got %b want 1", bus.fault); end
    tick();
    n_cmp++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL clear_one_red: got %b want 1", bus.fault); end
    tick();
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL clear_fault: got %b want 0", bus.fault); end
    n_cmp++; if (bus.fault_code !== 3'd0) begin n_err++; $display("FAIL clear_code: got %0d want 0", bus.fault_code); end
    n_cmp++; if (bus.flash_red !== 1'b0) begin n_err++; $display("FAIL clear_flash: got %b want 0", bus.flash_red); end
    n_cmp++; if (bus.force_override !== 1'b0) begin n_err++; $display("FAIL clear_override: got %b want 0", bus.force_override); end
  endtask

  task automatic test_multi_and_ignore();
    set_lamps(LR | LG, LR);
    tick();
    set_lamps(LR, LR);
    tick();
    n_cmp++; if (bus.fault_code !== 3'd2) begin n_err++; $display("FAIL multi_code: got %0d want 2", bus.fault_code); end
    n_cmp++; if (bus.fault_count !== 8'd2) begin n_err++; $display("FAIL multi_count: got %0d want 2", bus.fault_count); end
    inject_conflict();
    tick();
    n_cmp++; if (bus.fault_code !== 3'd2) begin n_err++; $display("FAIL ignore_code: got %0d want 2", bus.fault_code); end
    n_cmp++; if (bus.fault_count !== 8'd2) begin n_err++; $display("FAIL ignore_count: got %0d want 2", bus.fault_count); end
    do_clear();
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL multi_cleared: got %b want 0", bus.fault); end
  endtask

  task automatic test_short_yellow();
    set_lamps(LG, LR); tick();
    set_lamps(LY, LR); tick();
    tick();
    set_lamps(LR, LR); tick();
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL short_yellow_early: got %b want 0", bus.fault); end
    tick();
    n_cmp++; if (bus.fault_code !== 3'd4) begin n_err++; $display("FAIL short_yellow_code: got %0d want 4", bus.fault_code); end
    n_cmp++; if (bus.fault_count !== 8'd3) begin n_err++; $display("FAIL short_yellow_count: got %0d want 3", bus.fault_count); end
    do_clear();
  endtask

  // Short yellow on A coincides with R+G on B: MULTI outranks SHORT_YELLOW
  task automatic test_priority();
    set_lamps(LG, LR); tick();
    set_lamps(LY, LR); tick();
    tick();
    set_lamps(LR, LR | LG); tick();
    set_lamps(LR, LR); tick();
    n_cmp++; if (bus.fault_code !== 3'd2) begin n_err++; $display("FAIL priority_code: got %0d want 2", bus.fault_code); end
    n_cmp++; if (bus.fault_count !== 8'd4) begin n_err++; $display("FAIL priority_count: got %0d want 4", bus.fault_count); end
    do_clear();
  endtask

  task automatic test_dark();
    set_lamps(LR, OFF); tick(); tick();
    set_lamps(LR, LR); tick(); tick();
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL dark_two_cycles: got %b want 0", bus.fault); end
    set_lamps(LR, OFF); tick(); tick(); tick();
    set_lamps(LR, LR);
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL dark_latency: got %b want 0", bus.fault); end
    tick();
    n_cmp++; if (bus.fault_code !== 3'd3) begin n_err++; $display("FAIL dark_code: got %0d want 3", bus.fault_code); end
    n_cmp++; if (bus.fault_count !== 8'd5) begin n_err++; $display("FAIL dark_count: got %0d want 5", bus.fault_count); end
    do_clear();
  endtask

  task automatic test_sequence();
    set_lamps(LG, LR); tick();
    set_lamps(LR, LR); tick();
    tick();
    n_cmp++; if (bus.fault_code !== 3'd5) begin n_err++; $display("FAIL sequence_code: got %0d want 5", bus.fault_code); end
    n_cmp++; if (bus.fault_count !== 8'd6) begin n_err++; $display("FAIL sequence_count: got %0d want 6", bus.fault_count); end
    do_clear();
  endtask

  task automatic test_reset_mid_flash();
    inject_conflict();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL midreset_fault: got %b want 0", bus.fault); end
    n_cmp++; if (bus.fault_code !== 3'd0) begin n_err++; $display("FAIL midreset_code: got %0d want 0", bus.fault_code); end
    n_cmp++; if (bus.force_override !== 1'b0) begin n_err++; $display("FAIL midreset_override: got %b want 0", bus.force_override); end
    n_cmp++; if (bus.flash_red !== 1'b0) begin n_err++; $display("FAIL midreset_flash: got %b want 0", bus.flash_red); end
    n_cmp++; if (bus.fault_count !== 8'd0) begin n_err++; $display("FAIL midreset_count: got %0d want 0", bus.fault_count); end
  endtask

  task automatic test_saturation();
    tick();
    for (int k = 0; k < 260; k++) begin
      inject_conflict();
      do_clear();
    end
    n_cmp++; if (bus.fault_count !== 8'd255) begin n_err++; $display("FAIL saturate_count: got %0d want 255", bus.fault_count); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL saturate_cleared: got %b want 0", bus.fault); end
    inject_conflict();
    n_cmp++; if (bus.fault_code !== 3'd1) begin n_err++; $display("FAIL saturate_code: got %0d want 1", bus.fault_code); end
    n_cmp++; if (bus.fault_count !== 8'd255) begin n_err++; $display("FAIL saturate_hold: got %0d want 255", bus.fault_count); end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_conflict();
    test_multi_and_ignore();
    test_short_yellow();
    test_priority();
    test_dark();
    test_sequence();
    test_reset_mid_flash();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Independent safety monitor on the lamp outputs of traffic_light_controller (Ra, Ya, Ga, Rb, Yb, Gb).
- Checks every cycle for conflicting greens, illegal lamp combinations, dark heads, short yellows and illegal colour sequences.
- On the first violation it latches a fault code, asserts an override to the top level and drives an all-red flash pattern until software clears the fault.

Parameters:
- MIN_YELLOW, 3: minimum consecutive cycles a yellow must be lit before red.
- MAX_DARK, 2: maximum consecutive cycles a head may show no lamp.
- FLASH_HALF, 4: half-period of flash_red in clock cycles.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Ra, Ya, Ga  input  1 each  street A lamp drives from the controller.
- Rb, Yb, Gb  input  1 each  street B lamp drives from the controller.
- clear_fault  input  1  single-cycle request to leave the fault state.
- fault  output  1  high while a fault is latched.
- fault_code  output  3  code of the latched fault; 0 = none.
- force_override  output  1  top level replaces the controller lamps with the flash pattern.
- flash_red  output  1  blinking red for both heads while in fault.
- fault_count  output  8  saturating count of faults latched since reset.

Behaviour:
- Reset (reset=1 at an edge): state=MONITOR; fault=0, fault_code=0, force_override=0, flash_red=0, fault_count=0; all counters and history cleared; last colour per head = R.
- Input stage: the six lamps are registered once. Checks run on the registered copy.
- Latency: a violation present on the inputs at edge N gives fault=1 after edge N+1.
- A head is "active" when it shows G or Y. A head is "single" when exactly one of its R/Y/G is high.
- Fault codes, checked every cycle in MONITOR:
  - 1 CONFLICT: head A active and head B active.
  - 2 MULTI: more than one lamp lit on either head.
  - 3 DARK: a head has shown no lamp for MAX_DARK+1 consecutive cycles. Per-head dark counter, saturating.
  - 4 SHORT_YELLOW: a head goes from Y to R with yellow run length < MIN_YELLOW. Per-head yellow counter, saturating at MIN_YELLOW.
  - 5 SEQUENCE: a new single colour differs from the head's last single colour and is not a legal successor. Legal transitions are R→G, G→Y, Y→R. Dark cycles between colours do not reset the last colour.
- Simultaneous violations: the lowest code wins and only one fault is latched. Head A and head B violating the same code in the same cycle count as one fault.
- State machine:
  - MONITOR → FAULT on any violation. Latch fault_code, set fault and force_override, increment fault_count (saturates at 255).
  - FAULT: further violations are ignored, with no code change and no count change.
  - flash_red starts at 1 on the entry cycle and toggles every FLASH_HALF cycles.
  - FAULT → CLEARING on clear_fault=1.
  - CLEARING: fault and force_override stay 1 and flash continues. Wait until both registered heads show single R for 2 consecutive cycles, then go to MONITOR.
  - Entering MONITOR: fault=0, fault_code=0, flash_red=0, force_override=0; dark and yellow counters cleared; last colour = R for both heads.
  - clear_fault in MONITOR or CLEARING is ignored.
- Reset in any state, including mid-flash, returns everything to the reset values at the next edge.
- Wrap-around: fault_count saturates at 255 and never wraps. The flash counter wraps modulo FLASH_HALF.

Test Plan:
- Normal controller cycle (A: R→G 3 cycles→Y 3 cycles→R; B mirrors with no overlap) for 200 cycles → fault stays 0, fault_code=0, fault_count=0.
- Ga=1 and Gb=1 asserted together for one cycle → fault=1 two edges later, fault_code=1, force_override=1, fault_count=1, flash_red pattern 1111 0000 1111 (FLASH_HALF=4).
- Ya lit for 2 cycles then Ra → fault_code=4. Ra and Ga lit together in the same cycle → fault_code=2. Both in one cycle → code 2 wins.
- Head B all lamps off for 3 cycles → fault_code=3. Ga→Ra with no yellow → fault_code=5.
- In FAULT: pulse clear_fault, then hold Ra=Rb=1 for 2 cycles → fault=0, fault_code=0, flash_red=0. A conflict injected while in FAULT → fault_code and fault_count unchanged.
- Assert reset mid-flash → all outputs 0 after the edge. Inject 260 faults with clears in between → fault_count=255.
